// File: rtl/lt_sequencer.sv
// lt_sequencer: drives the test-pattern generator's lt_active/lt_mode, aligns each
// latency test to the generator's vsync, and times the photodiode response in
// microseconds. All outputs are registered copies of the next-state values.
module lt_sequencer #(
    parameter int          CLK_PER_US  = 27,
    parameter logic [15:0] TIMEOUT_US  = 16'd50000,
    parameter int          SENSOR_FILT = 4
) (
    input  logic        clk27,
    input  logic        reset,
    input  logic        lt_trigger,
    input  logic [1:0]  lt_mode_in,
    input  logic        vsync_in,
    input  logic        lt_sensor_n,
    output logic        lt_active,
    output logic [1:0]  lt_mode,
    output logic [15:0] lt_result,
    output logic        lt_finished,
    output logic        lt_timeout,
    output logic        lt_error
);

    localparam int            PW       = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_PER_US - 1);
    localparam logic [3:0]    FILT_MAX = 4'(SENSOR_FILT);

    typedef enum logic [1:0] {IDLE, SYNC_WAIT, MEASURE, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic [3:0]    filt_q;
    logic          vs_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   us_q, us_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   result_q, result_d;
    logic          timeout_q, timeout_d;
    logic          error_q, error_d;
    logic          active_q, active_d;
    logic          finished_q, finished_d;
    logic          lit;
    logic          vs_edge;

    // Sensor synchronizer + saturating lit filter, and one-stage vsync register.
    always_ff @(posedge clk27) begin
        if (reset) begin
            sync_q <= 2'b00;
            filt_q <= 4'd0;
            vs_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], lt_sensor_n};
            if (sync_q[1])
                filt_q <= 4'd0;
            else if (filt_q != FILT_MAX)
                filt_q <= filt_q + 4'd1;
            vs_q <= vsync_in;
        end
    end

    assign lit     = (filt_q == FILT_MAX);
    // Falling edge of the active-low vsync: registered copy high, live input low.
    assign vs_edge = vs_q & ~vsync_in;

    // State, timing counters and registered outputs.
    always_ff @(posedge clk27) begin
        if (reset) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            us_q       <= 16'd0;
            mode_q     <= 2'd0;
            result_q   <= 16'd0;
            timeout_q  <= 1'b0;
            error_q    <= 1'b0;
            active_q   <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            us_q       <= us_d;
            mode_q     <= mode_d;
            result_q   <= result_d;
            timeout_q  <= timeout_d;
            error_q    <= error_d;
            active_q   <= active_d;
            finished_q <= finished_d;
        end
    end

    // Next-state and datapath updates; trigger drop aborts ahead of lit/timeout.
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        us_d      = us_q;
        mode_d    = mode_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        error_d   = error_q;
        case (state_q)
            IDLE: begin
                if (lt_trigger && (lt_mode_in != 2'd0)) begin
                    mode_d    = lt_mode_in;
                    timeout_d = 1'b0;
                    error_d   = 1'b0;
                    if (lit) begin
                        error_d  = 1'b1;
                        result_d = 16'd0;
                        state_d  = DONE;
                    end else begin
                        state_d = SYNC_WAIT;
                    end
                end
            end
            SYNC_WAIT: begin
                if (!lt_trigger) begin
                    state_d = IDLE;
                end else if (vs_edge) begin
                    pre_d   = '0;
                    us_d    = 16'd0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!lt_trigger) begin
                    state_d = IDLE;
                end else if (lit) begin
                    result_d = us_q;
                    state_d  = DONE;
                end else if (us_q == TIMEOUT_US) begin
                    result_d  = TIMEOUT_US;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else if (pre_q == PRE_MAX) begin
                    pre_d = '0;
                    us_d  = us_q + 16'd1;
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            DONE: begin
                if (!lt_trigger)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        active_d   = (state_d == SYNC_WAIT) || (state_d == MEASURE);
        finished_d = (state_d == DONE);
    end

    assign lt_active   = active_q;
    assign lt_mode     = mode_q;
    assign lt_result   = result_q;
    assign lt_finished = finished_q;
    assign lt_timeout  = timeout_q;
    assign lt_error    = error_q;

endmodule
